// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift, rotate, arithmetic shift, load, clear.
// A saturating shift counter flags when a full word has been shifted.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (q=RESET_VAL, count cleared)
//   en        clock enable; 0 holds every piece of state
//   mode      operation select (HOLD/SHL/SHR/ROTL/ROTR/LOAD/CLR/ASR)
//   d         parallel load data
//   sin_l     serial in at LSB on shift-left
//   sin_r     serial in at MSB on shift-right
//   q         register contents
//   so_msb    q[WIDTH-1], the bit that leaves on SHL
//   so_lsb    q[0], the bit that leaves on SHR
//   shift_cnt shifts since last load/clear, saturating at WIDTH
//   done      registered flag, 1 exactly when shift_cnt == WIDTH
module universal_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [2:0]                     mode,
    input  logic [WIDTH-1:0]               d,
    input  logic                           sin_l,
    input  logic                           sin_r,
    output logic [WIDTH-1:0]               q,
    output logic                           so_msb,
    output logic                           so_lsb,
    output logic [$clog2(WIDTH+1)-1:0]     shift_cnt,
    output logic                           done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROTL = 3'b011;
    localparam logic [2:0] M_ROTR = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;
    localparam logic [2:0] M_ASR  = 3'b111;

    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_next;
    logic [CW-1:0]    cnt_inc;

    // Saturating increment: the counter parks at WIDTH instead of wrapping.
    assign cnt_inc = (shift_cnt == CNT_MAX) ? shift_cnt : shift_cnt + 1'b1;

    always_comb begin
        q_next   = q;
        cnt_next = shift_cnt;
        unique case (mode)
            M_HOLD: begin
                q_next   = q;
                cnt_next = shift_cnt;
            end
            M_SHL: begin
                q_next   = {q[WIDTH-2:0], sin_l};
                cnt_next = cnt_inc;
            end
            M_SHR: begin
                q_next   = {sin_r, q[WIDTH-1:1]};
                cnt_next = cnt_inc;
            end
            M_ROTL: begin
                q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
                cnt_next = cnt_inc;
            end
            M_ROTR: begin
                q_next   = {q[0], q[WIDTH-1:1]};
                cnt_next = cnt_inc;
            end
            M_LOAD: begin
                q_next   = d;
                cnt_next = '0;
            end
            M_CLR: begin
                q_next   = '0;
                cnt_next = '0;
            end
            M_ASR: begin
                q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
                cnt_next = cnt_inc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= RESET_VAL;
            shift_cnt <= '0;
            done      <= 1'b0;
        end else if (en) begin
            q         <= q_next;
            shift_cnt <= cnt_next;
            // Registered alongside the counter so it tracks it exactly.
            done      <= (cnt_next == CNT_MAX);
        end
    end

    assign so_msb = q[WIDTH-1];
    assign so_lsb = q[0];

endmodule
